// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: bundles the serial input, baud tick, consumer handshake and
// receive status of uart_rx_ctrl.
//   master : drives rx, baud_tick, rx_ack; observes received word and status
//   slave  : the receiver itself
// The break_det signal exists only when UART_RX_BREAK_DET_EN is defined.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 baud_tick;
  logic                 rx_ack;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 busy;
`ifdef UART_RX_BREAK_DET_EN
  logic                 break_det;

  modport master (
    output rx, baud_tick, rx_ack,
    input  rx_data, rx_valid, parity_err, frame_err, overrun_err, busy, break_det
  );
  modport slave (
    input  rx, baud_tick, rx_ack,
    output rx_data, rx_valid, parity_err, frame_err, overrun_err, busy, break_det
  );
`else
  modport master (
    output rx, baud_tick, rx_ack,
    input  rx_data, rx_valid, parity_err, frame_err, overrun_err, busy
  );
  modport slave (
    input  rx, baud_tick, rx_ack,
    output rx_data, rx_valid, parity_err, frame_err, overrun_err, busy
  );
`endif
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller. Start/data/parity/stop framing with an
// oversample tick counter, mid-bit sampling, false-start rejection, parity, framing
// and overrun detection, and a level rx_valid held until rx_ack.
// Ports:
//   clk  clock
//   rst  asynchronous reset, active low
//   bus  uart_rx_ctrl_if.slave: rx, baud_tick, rx_ack in; rx_data, rx_valid,
//        parity_err, frame_err, overrun_err, busy (and break_det) out
// Optional feature: define UART_RX_BREAK_DET_EN to turn an all-zero frame into a
// one-clock break_det pulse instead of a received word.
//
// state  | meaning
// IDLE   | line idle, waiting for rxs low
// START  | counting to mid start bit, rejects false starts
// DATA   | sampling DATA_BITS data bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling stop bits; also holds after a break until the line goes high
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_ctrl_if.slave  bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nxt;

  logic                 rx_meta, rxs;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 pe_acc, fe_acc;
  logic                 half_pt, mid_pt, bit_last, stop_last;
  logic                 done, is_brk, brk_wait, busy_c;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r, parity_err_r, frame_err_r, overrun_err_r;

  assign half_pt   = bus.baud_tick && (tcnt == TW'(OVERSAMPLE/2 - 1));
  assign mid_pt    = bus.baud_tick && (tcnt == TW'(OVERSAMPLE - 1));
  assign bit_last  = (bit_idx == BW'(DATA_BITS - 1));
  assign stop_last = (STOP_BITS == 1) || stop_idx;

`ifdef UART_RX_BREAK_DET_EN
  logic any_one;
  logic break_det_r;
  // Break: every sampled bit of the frame, including the final stop sample, was 0.
  assign is_brk = !any_one && !rxs;
`else
  assign is_brk   = 1'b0;
  assign brk_wait = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rxs) state_nxt = START;
      START:   if (half_pt) state_nxt = rxs ? IDLE : DATA;
      DATA:    if (mid_pt && bit_last) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (mid_pt) state_nxt = STOP;
      STOP: begin
        if (brk_wait) begin
          if (rxs) state_nxt = IDLE;
        end else if (done && !is_brk) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // output / strobe logic
  always_comb begin
    busy_c = (state != IDLE);
    done   = (state == STOP) && !brk_wait && mid_pt && stop_last;
  end

  // synchronizer, counters and frame accumulators
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      tcnt     <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      pe_acc   <= 1'b0;
      fe_acc   <= 1'b0;
    end else begin
      rx_meta <= bus.rx;
      rxs     <= rx_meta;
      if (state_nxt != state || state == IDLE)
        tcnt <= '0;
      else if (bus.baud_tick)
        tcnt <= (tcnt == TW'(OVERSAMPLE - 1)) ? '0 : tcnt + TW'(1);
      if (state == START) begin
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        pe_acc   <= 1'b0;
        fe_acc   <= 1'b0;
      end
      if (state == DATA && mid_pt) begin
        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + BW'(1);
      end
      if (state == PARITY && mid_pt)
        pe_acc <= ((^shreg) ^ rxs) != (PARITY_ODD != 0);
      if (state == STOP && mid_pt && !brk_wait) begin
        stop_idx <= 1'b1;
        if (!rxs) fe_acc <= 1'b1;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      any_one     <= 1'b0;
      brk_wait    <= 1'b0;
      break_det_r <= 1'b0;
    end else begin
      break_det_r <= done && is_brk;
      if (state == START) any_one <= 1'b0;
      else if ((state == DATA || state == PARITY || state == STOP) && mid_pt && rxs)
        any_one <= 1'b1;
      if (done && is_brk)        brk_wait <= 1'b1;
      else if (state_nxt == IDLE) brk_wait <= 1'b0;
    end
  end
  assign bus.break_det = break_det_r;
`endif

  // received word and status; a completion takes priority over a bare ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_r     <= '0;
      rx_valid_r    <= 1'b0;
      parity_err_r  <= 1'b0;
      frame_err_r   <= 1'b0;
      overrun_err_r <= 1'b0;
    end else if (done && !is_brk) begin
      if (!rx_valid_r || bus.rx_ack) begin
        rx_data_r     <= shreg;
        rx_valid_r    <= 1'b1;
        parity_err_r  <= pe_acc;
        frame_err_r   <= fe_acc | !rxs;
        overrun_err_r <= 1'b0;
      end else begin
        overrun_err_r <= 1'b1;
      end
    end else if (bus.rx_ack && rx_valid_r) begin
      rx_valid_r    <= 1'b0;
      parity_err_r  <= 1'b0;
      frame_err_r   <= 1'b0;
      overrun_err_r <= 1'b0;
    end
  end

  assign bus.rx_data     = rx_data_r;
  assign bus.rx_valid    = rx_valid_r;
  assign bus.parity_err  = parity_err_r;
  assign bus.frame_err   = frame_err_r;
  assign bus.overrun_err = overrun_err_r;
  assign bus.busy        = busy_c;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
  localparam int BIT_CLKS = 64;  // 16 ticks x 4 clk

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   brk_cnt = 0;

  uart_rx_ctrl_if #(.DATA_BITS(8)) bus();

  uart_rx_ctrl #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    bus.baud_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.baud_tick = 1'b1;
      @(negedge clk);
      bus.baud_tick = 1'b0;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  initial forever begin
    @(negedge clk);
    if (bus.break_det === 1'b1) brk_cnt++;
  end
`endif

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask

  // A 0 stop bit is only held for part of the bit so the line is high again
  // before the receiver could mistake it for a new start bit.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
    drive_bit(p, BIT_CLKS);
    if (s) drive_bit(1'b1, BIT_CLKS);
    else begin
      drive_bit(1'b0, 40);
      drive_bit(1'b1, BIT_CLKS - 40);
    end
  endtask

  task automatic pulse_ack();
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{d: 8'hA5, p: 1'b0, s: 1'b1, exp_data: 8'hA5, exp_pe: 1'b0, exp_fe: 1'b0};
    vecs[1] = '{d: 8'h3C, p: 1'b1, s: 1'b1, exp_data: 8'h3C, exp_pe: 1'b1, exp_fe: 1'b0};
    vecs[2] = '{d: 8'h55, p: 1'b0, s: 1'b0, exp_data: 8'h55, exp_pe: 1'b0, exp_fe: 1'b1};
    vecs[3] = '{d: 8'h01, p: 1'b1, s: 1'b1, exp_data: 8'h01, exp_pe: 1'b0, exp_fe: 1'b0};
    vecs[4] = '{d: 8'h80, p: 1'b0, s: 1'b1, exp_data: 8'h80, exp_pe: 1'b1, exp_fe: 1'b0};
    vecs[5] = '{d: 8'hFF, p: 1'b0, s: 1'b1, exp_data: 8'hFF, exp_pe: 1'b0, exp_fe: 1'b0};

    bus.rx = 1'b1;
    bus.rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", bus.rx_valid, 0);
    check("reset_data", bus.rx_data, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_errs", {bus.parity_err, bus.frame_err, bus.overrun_err}, 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // ack with nothing pending has no effect
    pulse_ack();
    check("idle_ack_valid", bus.rx_valid, 0);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].d, vecs[v].p, vecs[v].s);
      repeat (40) @(negedge clk);
      check($sformatf("v%0d_valid", v), bus.rx_valid, 1);
      check($sformatf("v%0d_data", v), bus.rx_data, vecs[v].exp_data);
      check($sformatf("v%0d_pe", v), bus.parity_err, vecs[v].exp_pe);
      check($sformatf("v%0d_fe", v), bus.frame_err, vecs[v].exp_fe);
      check($sformatf("v%0d_ov", v), bus.overrun_err, 0);
      check($sformatf("v%0d_busy", v), bus.busy, 0);
      pulse_ack();
      check($sformatf("v%0d_ack_valid", v), bus.rx_valid, 0);
      check($sformatf("v%0d_ack_errs", v), {bus.parity_err, bus.frame_err}, 0);
    end

    // false start: 5 ticks low then high
    bus.rx = 1'b0;
    repeat (10) @(negedge clk);
    check("fs_busy_hi", bus.busy, 1);
    repeat (10) @(negedge clk);
    bus.rx = 1'b1;
    repeat (60) @(negedge clk);
    check("fs_busy_lo", bus.busy, 0);
    check("fs_valid", bus.rx_valid, 0);

    // overrun: two frames without ack
    send_frame(8'h11, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("ov1_data", bus.rx_data, 8'h11);
    check("ov1_ov", bus.overrun_err, 0);
    send_frame(8'h22, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    check("ov2_valid", bus.rx_valid, 1);
    check("ov2_data", bus.rx_data, 8'h11);
    check("ov2_ov", bus.overrun_err, 1);
    pulse_ack();
    check("ov_ack_valid", bus.rx_valid, 0);
    check("ov_ack_ov", bus.overrun_err, 0);

    // line held low for 12 bit times
    bus.rx = 1'b0;
    repeat (700) @(negedge clk);
`ifdef UART_RX_BREAK_DET_EN
    repeat (60) @(negedge clk);
    check("brk_pulses", brk_cnt, 1);
    check("brk_valid", bus.rx_valid, 0);
    check("brk_fe", bus.frame_err, 0);
    check("brk_busy_wait", bus.busy, 1);
    bus.rx = 1'b1;
    repeat (40) @(negedge clk);
    check("brk_busy_lo", bus.busy, 0);
    check("brk_pulses_end", brk_cnt, 1);
`else
    check("brk_valid", bus.rx_valid, 1);
    check("brk_data", bus.rx_data, 0);
    check("brk_fe", bus.frame_err, 1);
    check("brk_pe", bus.parity_err, 0);
    repeat (BIT_CLKS * 12 - 700) @(negedge clk);
    bus.rx = 1'b1;
`endif
    repeat (1000) @(negedge clk);
    pulse_ack();
    check("post_brk_valid", bus.rx_valid, 0);
    check("post_brk_ov", bus.overrun_err, 0);

    // reset mid-frame with a word pending
    send_frame(8'h3C, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("pre_rst_valid", bus.rx_valid, 1);
    drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS * 2);
    check("pre_rst_busy", bus.busy, 1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", bus.rx_valid, 0);
    check("rst_data", bus.rx_data, 0);
    check("rst_errs", {bus.parity_err, bus.frame_err, bus.overrun_err}, 0);
    check("rst_busy", bus.busy, 0);
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_idle_busy", bus.busy, 0);

    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    check("recov_valid", bus.rx_valid, 1);
    check("recov_data", bus.rx_data, 8'hA5);
    check("recov_errs", {bus.parity_err, bus.frame_err, bus.overrun_err}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
